// File: rtl/player_executor.sv
`default_nettype none
// ============================================================================
// Module   : player_executor
// Brief    : Applies DODGE-page player ops (move/damage/heal/set-HP/centre),
//            owns soul position, HP and the post-hit invulnerability window.
// Revision : 1.0 - initial release
// ============================================================================
module player_executor #(
    parameter int X_MIN         = 220,
    parameter int X_MAX         = 420,
    parameter int Y_MIN         = 260,
    parameter int Y_MAX         = 420,
    parameter int STEP          = 2,
    parameter int MOVE_DIV      = 250000,
    parameter int IFRAME_CYCLES = 50000000,
    parameter int MAX_HP        = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        is_move,
    output logic [9:0]  player_x,
    output logic [9:0]  player_y,
    output logic [7:0]  player_hp,
    output logic        is_death,
    output logic        invuln,
    output logic        hp_ack
);

    localparam int c_MW = ($clog2(MOVE_DIV) < 1) ? 1 : $clog2(MOVE_DIV);
    localparam int c_IW = ($clog2(IFRAME_CYCLES) < 1) ? 1 : $clog2(IFRAME_CYCLES);

    localparam logic [c_MW-1:0] c_MOVE_LAST = c_MW'(MOVE_DIV - 1);
    localparam logic [c_IW-1:0] c_IFR_LAST  = c_IW'(IFRAME_CYCLES - 1);

    localparam logic [9:0] c_X_MIN = 10'(X_MIN);
    localparam logic [9:0] c_X_MAX = 10'(X_MAX);
    localparam logic [9:0] c_Y_MIN = 10'(Y_MIN);
    localparam logic [9:0] c_Y_MAX = 10'(Y_MAX);
    localparam logic [9:0] c_X_CTR = 10'((X_MIN + X_MAX) / 2);
    localparam logic [9:0] c_Y_CTR = 10'((Y_MIN + Y_MAX) / 2);
    localparam logic [9:0] c_STEP  = 10'(STEP);
    localparam logic [7:0] c_HPMAX = 8'(MAX_HP);

    localparam logic [1:0] c_ST_ALIVE  = 2'd0;
    localparam logic [1:0] c_ST_IFRAME = 2'd1;
    localparam logic [1:0] c_ST_DEAD   = 2'd2;

    localparam logic [3:0] c_OP_HPY = 4'h1;
    localparam logic [3:0] c_OP_DPY = 4'h2;
    localparam logic [3:0] c_OP_IDG = 4'h3;
    localparam logic [3:0] c_OP_MOV = 4'h5;
    localparam logic [3:0] c_OP_SHP = 4'h6;

    logic [1:0]      r_state, w_state_nxt;
    logic [9:0]      r_x, w_x_nxt;
    logic [9:0]      r_y, w_y_nxt;
    logic [7:0]      r_hp, w_hp_nxt;
    logic [c_MW-1:0] r_mcnt, w_mcnt_nxt;
    logic [c_IW-1:0] r_icnt, w_icnt_nxt;
    logic            r_death, r_invuln, r_ack, w_ack_nxt;

    logic [3:0] w_op;
    logic [7:0] w_operand;
    logic [8:0] w_hp_sum;
    logic [9:0] w_x_dn, w_x_up, w_y_dn, w_y_up;
    logic       w_live;
    logic       w_unused;

    assign w_op      = instr[15:12];
    assign w_operand = instr[11:4];
    assign w_unused  = ^instr[3:0];
    assign w_live    = (r_state != c_ST_DEAD);
    assign w_hp_sum  = {1'b0, r_hp} + {1'b0, w_operand};

    // Clamp checks done before subtracting so positions never wrap below zero
    assign w_x_dn = ({1'b0, r_x} < 11'(X_MIN + STEP)) ? c_X_MIN : (r_x - c_STEP);
    assign w_y_dn = ({1'b0, r_y} < 11'(Y_MIN + STEP)) ? c_Y_MIN : (r_y - c_STEP);
    assign w_x_up = (({1'b0, r_x} + 11'(STEP)) > 11'(X_MAX)) ? c_X_MAX : (r_x + c_STEP);
    assign w_y_up = (({1'b0, r_y} + 11'(STEP)) > 11'(Y_MAX)) ? c_Y_MAX : (r_y + c_STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hp_nxt    = r_hp;
        w_mcnt_nxt  = '0;
        w_icnt_nxt  = r_icnt;
        w_ack_nxt   = 1'b0;

        if (r_state == c_ST_IFRAME) begin
            if (r_icnt == c_IFR_LAST) begin
                w_state_nxt = c_ST_ALIVE;
                w_icnt_nxt  = '0;
            end else begin
                w_icnt_nxt = r_icnt + 1'b1;
            end
        end

        if (w_op == c_OP_MOV && is_move && w_live) begin
            if (r_mcnt == c_MOVE_LAST) begin
                case (w_operand)
                    8'd0:    w_y_nxt = w_y_dn;
                    8'd1:    w_x_nxt = w_x_dn;
                    8'd2:    w_y_nxt = w_y_up;
                    8'd3:    w_x_nxt = w_x_up;
                    default: ;
                endcase
            end else begin
                w_mcnt_nxt = r_mcnt + 1'b1;
            end
        end

        case (w_op)
            c_OP_HPY: begin
                if (r_state == c_ST_ALIVE) begin
                    w_hp_nxt    = (w_hp_sum > {1'b0, c_HPMAX}) ? c_HPMAX : w_hp_sum[7:0];
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = c_ST_IFRAME;
                    w_icnt_nxt  = '0;
                end
            end
            c_OP_DPY: begin
                if (r_state == c_ST_ALIVE) begin
                    w_ack_nxt = 1'b1;
                    if (w_operand >= r_hp) begin
                        w_hp_nxt    = 8'd0;
                        w_state_nxt = c_ST_DEAD;
                    end else begin
                        w_hp_nxt    = r_hp - w_operand;
                        w_state_nxt = c_ST_IFRAME;
                        w_icnt_nxt  = '0;
                    end
                end
            end
            c_OP_SHP: begin
                w_hp_nxt    = (w_operand > c_HPMAX) ? c_HPMAX : w_operand;
                w_ack_nxt   = 1'b1;
                w_icnt_nxt  = '0;
                w_state_nxt = (w_operand != 8'd0) ? c_ST_ALIVE : c_ST_DEAD;
            end
            c_OP_IDG: begin
                if (w_live) begin
                    w_x_nxt = c_X_CTR;
                    w_y_nxt = c_Y_CTR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_ALIVE;
            r_x      <= c_X_CTR;
            r_y      <= c_Y_CTR;
            r_hp     <= c_HPMAX;
            r_mcnt   <= '0;
            r_icnt   <= '0;
            r_death  <= 1'b0;
            r_invuln <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_hp     <= w_hp_nxt;
            r_mcnt   <= w_mcnt_nxt;
            r_icnt   <= w_icnt_nxt;
            r_death  <= (w_state_nxt == c_ST_DEAD);
            r_invuln <= (w_state_nxt == c_ST_IFRAME);
            r_ack    <= w_ack_nxt;
        end
    end

    assign player_x  = r_x;
    assign player_y  = r_y;
    assign player_hp = r_hp;
    assign is_death  = r_death;
    assign invuln    = r_invuln;
    assign hp_ack    = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_player_executor.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_executor
// Brief    : Directed vectors and cycle-exact sequences for player_executor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_executor;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        is_move;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [7:0]  player_hp;
    logic        is_death;
    logic        invuln;
    logic        hp_ack;

    int n_tests = 0;
    int n_fail  = 0;

    player_executor #(
        .STEP          (2),
        .MOVE_DIV      (4),
        .IFRAME_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .is_move   (is_move),
        .player_x  (player_x),
        .player_y  (player_y),
        .player_hp (player_hp),
        .is_death  (is_death),
        .invuln    (invuln),
        .hp_ack    (hp_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        mv;
        int          n;
        int          ex;
        int          ey;
        int          ehp;
        logic        ed;
        logic        ei;
        int          eacks;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] ins, input logic mv, input int n, output int acks);
        instr   = ins;
        is_move = mv;
        acks    = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            acks += int'(hp_ack);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int ey, input int ehp,
                           input int ed, input int ei);
        chk({tag, ".x"},      int'(player_x),  ex);
        chk({tag, ".y"},      int'(player_y),  ey);
        chk({tag, ".hp"},     int'(player_hp), ehp);
        chk({tag, ".death"},  int'(is_death),  ed);
        chk({tag, ".invuln"}, int'(invuln),    ei);
    endtask

    initial begin
        int acks;

        //                instr     mv  n    x    y    hp  d  i  acks
        vecs[0]  = '{16'h2320, 1'b0, 1,   328, 340, 0,   1, 0, 1};  // DPY 50 at hp 40 kills
        vecs[1]  = '{16'h5030, 1'b1, 8,   328, 340, 0,   1, 0, 0};  // MOV ignored while dead
        vecs[2]  = '{16'h10A0, 1'b0, 3,   328, 340, 0,   1, 0, 0};  // HPY ignored while dead
        vecs[3]  = '{16'h3000, 1'b0, 2,   328, 340, 0,   1, 0, 0};  // IDG ignored while dead
        vecs[4]  = '{16'h6C80, 1'b0, 1,   328, 340, 100, 0, 0, 1};  // SHP 200 revives, clamps
        vecs[5]  = '{16'h0000, 1'b0, 2,   328, 340, 100, 0, 0, 0};
        vecs[6]  = '{16'h6000, 1'b0, 1,   328, 340, 0,   1, 0, 1};  // SHP 0 kills
        vecs[7]  = '{16'h65A0, 1'b0, 1,   328, 340, 90,  0, 0, 1};  // SHP 90
        vecs[8]  = '{16'h5050, 1'b1, 8,   328, 340, 90,  0, 0, 0};  // bad direction
        vecs[9]  = '{16'h5030, 1'b0, 8,   328, 340, 90,  0, 0, 0};  // is_move low
        vecs[10] = '{16'h4000, 1'b0, 2,   328, 340, 90,  0, 0, 0};  // SDG
        vecs[11] = '{16'hF000, 1'b0, 2,   328, 340, 90,  0, 0, 0};  // unknown opcode
        vecs[12] = '{16'h3000, 1'b0, 1,   320, 340, 90,  0, 0, 0};  // IDG recentre
        vecs[13] = '{16'h5010, 1'b1, 196, 222, 340, 90,  0, 0, 0};  // 49 left steps
        vecs[14] = '{16'h5010, 1'b1, 4,   220, 340, 90,  0, 0, 0};
        vecs[15] = '{16'h5010, 1'b1, 8,   220, 340, 90,  0, 0, 0};  // clamped at X_MIN
        vecs[16] = '{16'h5000, 1'b1, 160, 220, 260, 90,  0, 0, 0};  // 40 up steps
        vecs[17] = '{16'h5000, 1'b1, 8,   220, 260, 90,  0, 0, 0};  // clamped at Y_MIN
        vecs[18] = '{16'h1320, 1'b0, 1,   220, 260, 100, 0, 1, 1};  // HPY 50 at 90
        vecs[19] = '{16'h0000, 1'b0, 3,   220, 260, 100, 0, 1, 0};  // still in window

        rst_n   = 1'b0;
        instr   = 16'h0000;
        is_move = 1'b0;
        tick();
        tick();
        chk_all("reset", 320, 340, 100, 0, 0);
        chk("reset.ack", int'(hp_ack), 0);

        rst_n = 1'b1;
        run(16'h0000, 1'b0, 5, acks);
        chk_all("idle", 320, 340, 100, 0, 0);
        chk("idle.acks", acks, 0);

        // Move right: one step every 4 held cycles, counter restarts on release
        instr   = 16'h5030;
        is_move = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("mov_r.c%0d", k), int'(player_x), 320 + 2 * (k / 4));
        end
        is_move = 1'b0;
        tick();
        chk("mov_r.release", int'(player_x), 326);
        is_move = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("mov_r.restart%0d", k), int'(player_x), (k < 4) ? 326 : 328);
        end

        // Held DPY 30: one hit per window, re-hit the cycle after the window ends
        instr   = 16'h21E0;
        is_move = 1'b0;
        acks    = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            acks += int'(hp_ack);
            chk($sformatf("dpy.inv%0d", k), int'(invuln),
                ((k <= 8) || (k >= 10 && k <= 17)) ? 1 : 0);
            chk($sformatf("dpy.hp%0d", k), int'(player_hp), (k < 10) ? 70 : 40);
        end
        chk("dpy.acks", acks, 2);

        for (int i = 0; i < 20; i++) begin
            run(vecs[i].instr, vecs[i].mv, vecs[i].n, acks);
            chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ehp,
                    int'(vecs[i].ed), int'(vecs[i].ei));
            chk($sformatf("vec%0d.acks", i), acks, vecs[i].eacks);
        end

        // Reset in the middle of an invulnerability window
        rst_n = 1'b0;
        instr = 16'h0000;
        tick();
        chk_all("rst_mid", 320, 340, 100, 0, 0);
        chk("rst_mid.ack", int'(hp_ack), 0);
        rst_n = 1'b1;
        run(16'h2050, 1'b0, 1, acks);
        chk("post_rst.hp", int'(player_hp), 95);
        chk("post_rst.acks", acks, 1);
        chk("post_rst.invuln", int'(invuln), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
